uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of byte requesters (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: single system clock, 50 MHz.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, NUM_REQ bits: requester i has a byte pending.
REQ-005 SHALL have port req_data, input, 8*NUM_REQ bits: byte of requester i, in bits [8i+7:8i].
REQ-006 SHALL have port req_last, input, NUM_REQ bits: the pending byte ends the requester's message.
REQ-007 SHALL have port req_ready, output, NUM_REQ bits: one-hot single-cycle accept pulse to requester i.
REQ-008 SHALL have port uart_tx_data, output, 8 bits: byte presented to the UART transmitter.
REQ-009 SHALL have port uart_tx_start, output, 1 bit: single-cycle start strobe to the UART transmitter.
REQ-010 SHALL have port uart_tx_busy, input, 1 bit: UART transmitter busy flag.
REQ-011 SHALL have port grant_id, output, 3 bits: index of the current or last granted requester.
REQ-012 SHALL have port arb_busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-014 In IDLE with uart_tx_busy=0 and any req_valid set, SHALL select a requester by round-robin, starting the search at (last grant + 1) mod NUM_REQ.
REQ-015 In that same IDLE cycle SHALL drive req_ready[sel]=1 combinationally, register req_data[sel] into uart_tx_data, update grant_id, and go to LAUNCH.
REQ-016 In IDLE with uart_tx_busy=1 (external or stale activity), SHALL grant nothing and remain in IDLE.
REQ-017 In LAUNCH SHALL drive uart_tx_start=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-018 In WAIT_BUSY SHALL go to WAIT_DONE when uart_tx_busy=1.
REQ-019 In WAIT_BUSY SHALL fall back to WAIT_DONE after 4 cycles without busy, so a missed busy cannot hang the FSM.
REQ-020 In WAIT_DONE SHALL return to IDLE on the first cycle with uart_tx_busy=0.
REQ-021 Latency: accept at cycle N, uart_tx_start at N+1; the minimum spacing between accepts SHALL be one UART frame plus 3 cycles.
REQ-022 uart_tx_data SHALL hold stable from LAUNCH until the next accept.
REQ-023 At most one req_ready bit SHALL be set in any cycle.
REQ-024 req_ready SHALL never be asserted outside IDLE.
REQ-025 A requester deasserting req_valid before it receives req_ready SHALL lose its turn without error.
REQ-026 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-027 With a single requester active, that requester SHALL be granted back-to-back.
REQ-028 With all requesters valid, the grant order SHALL be 0,1,2,...,NUM_REQ-1,0, starting from the post-reset pointer.

Reset
REQ-029 On reset, the FSM SHALL enter IDLE; req_ready=0, uart_tx_start=0, uart_tx_data=8'h00, grant_id=NUM_REQ-1 (so requester 0 wins first), arb_busy=0, lock cleared.
REQ-030 Reset asserted mid-operation SHALL abort immediately, with no further start strobe.
REQ-031 After reset, the block SHALL obey REQ-016 before granting again.

Configuration
REQ-032 SHALL support macro UART_ARB_MSG_LOCK_EN.
REQ-033 When UART_ARB_MSG_LOCK_EN is defined: after an accept with req_last=0, IDLE SHALL consider only the locked requester until a byte with req_last=1 is accepted.
REQ-034 Under the lock, other requesters SHALL stall, and the round-robin pointer SHALL be frozen.
REQ-035 When UART_ARB_MSG_LOCK_EN is undefined: req_last SHALL be ignored and arbitration SHALL occur per byte.

Structure
REQ-036 The FSM state encoding, the WAIT_BUSY timeout constant (4), and the 8-bit byte width SHALL live in package uart_pkg, shared with other UART-side blocks.
REQ-037 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, index); the rest SHALL be flat.

Verification
REQ-038 After reset, req_valid=4'b0001 with data 8'h41 -> req_ready[0] pulse, uart_tx_start one cycle later, uart_tx_data=8'h41, and return to IDLE after the UART drops busy.
REQ-039 req_valid=4'b1111 held, data 8'h30+i -> UART byte sequence 30,31,32,33,30; no double ready in any cycle.
REQ-040 Lock enabled: requester 2 sends 3 bytes (req_last on the third) while requester 0 is valid -> bytes 2,2,2 then 0. Lock disabled -> 2,0 interleaved.
REQ-041 Stub UART never raises busy -> the FSM returns to IDLE 4 cycles after WAIT_BUSY entry plus 1, with no hang.
REQ-042 Reset pulse during WAIT_DONE -> all outputs at reset values in the same cycle; the next grant goes to requester 0.
REQ-043 uart_tx_busy held high externally while req_valid=4'b0100 -> no req_ready until busy falls, then grant to requester 2.

Source files
------------

// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------
// | Module   : uart_pkg
// | Purpose  : Shared UART-side types and constants (byte width, arbiter FSM
// |            encoding, WAIT_BUSY timeout).
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int unsigned c_byte_w       = 8;
  localparam int unsigned c_wait_timeout = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------
// | Module   : rr_arbiter
// | Purpose  : Combinational round-robin pick; search starts one past ptr_i.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [2:0]         idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [3:0]           w_shamt;

  // Rotate so bit 0 of w_rot is the first candidate after the last grant.
  assign w_dbl   = {req_i, req_i};
  assign w_shamt = {1'b0, ptr_i} + 4'd1;
  assign w_rot   = NUM_REQ'(w_dbl >> w_shamt);

  always_comb begin
    idx_o   = '0;
    any_o   = 1'b0;
    grant_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        idx_o = 3'((int'(ptr_i) + 1 + k) % NUM_REQ);
        any_o = 1'b1;
      end
    end
    if (any_o) begin
      grant_o = NUM_REQ'(1) << idx_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------------
// | Module   : uart_tx_arbiter
// | Purpose  : Round-robin arbiter feeding bytes from NUM_REQ requesters into a
// |            single UART transmitter. Optional message lock via macro
// |            UART_ARB_MSG_LOCK_EN.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [c_byte_w*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [c_byte_w-1:0]          uart_tx_data,
  output logic                         uart_tx_start,
  input  logic                         uart_tx_busy,
  output logic [2:0]                   grant_id,
  output logic                         arb_busy
);

  arb_state_e          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [c_byte_w-1:0] data_q, data_d;
  logic [2:0]          gid_q, gid_d;

  logic [NUM_REQ-1:0]  w_req_eff;
  logic [NUM_REQ-1:0]  w_grant;
  logic [2:0]          w_idx;
  logic                w_any;
  logic [c_byte_w-1:0] w_sel_byte;

`ifdef UART_ARB_MSG_LOCK_EN
  logic lock_q, lock_d;

  // While locked only the last-granted requester may win; gid_q doubles as the
  // frozen pointer because it equals the lock owner.
  assign w_req_eff = lock_q ? (req_valid & (NUM_REQ'(1) << gid_q)) : req_valid;

  always_comb begin
    lock_d = lock_q;
    if (|req_ready) begin
      lock_d = ~|(req_last & w_grant);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign w_req_eff   = req_valid;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i   (w_req_eff),
    .ptr_i   (gid_q),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  assign w_sel_byte = c_byte_w'(req_data >> (int'(w_idx) * c_byte_w));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    gid_d         = gid_q;
    req_ready     = '0;
    uart_tx_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gate with reset so no accept pulse leaks out while reset is held.
        if (!uart_tx_busy && !reset && w_any) begin
          req_ready = w_grant;
          data_d    = w_sel_byte;
          gid_d     = w_idx;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        uart_tx_start = 1'b1;
        cnt_d         = '0;
        state_d       = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (uart_tx_busy || (cnt_q == 3'(c_wait_timeout - 1))) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      gid_q   <= 3'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end

  assign uart_tx_data = data_q;
  assign grant_id     = gid_q;
  assign arb_busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +----------------------------------------------------------------------------
// | Module   : tb_uart_tx_arbiter
// | Purpose  : Randomized scoreboard bench for uart_tx_arbiter with a stub UART.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_start;
  logic           uart_tx_busy;
  logic [2:0]     grant_id;
  logic           arb_busy;

  always #10 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .grant_id      (grant_id),
    .arb_busy      (arb_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] id;
    int         start_cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         n_checks   = 0;
  int         n_fail     = 0;
  int         cyc        = 0;
  int         idle_from  = 0;
  int         busy_from  = 0;
  int         busy_until = -1;
  int         ptr        = N - 1;
  bit         locked     = 1'b0;
  int         lock_id    = 0;
  logic [7:0] last_data  = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first valid requester after the previous grant, wrapping.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, predict the arbiter's response, check it.
  // flen = UART frame length in busy cycles (0 = stub never raises busy);
  // ext = stray busy while the arbiter is expected idle.
  task automatic cycle(input logic [N-1:0] v, input int flen, input bit ext);
    logic [N-1:0] eff;
    logic [N-1:0] exp_ready;
    logic         busy_c;
    bit           exp_ab;
    int           sel;
    exp_t         e;
    req_valid = v;
    req_last  = N'($urandom);
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
    busy_c = ((cyc >= busy_from) && (cyc <= busy_until)) || (ext && (cyc >= idle_from));
    uart_tx_busy = busy_c;
    exp_ab    = (cyc < idle_from);
    exp_ready = '0;
    if ((cyc >= idle_from) && !busy_c) begin
      eff = v;
`ifdef UART_ARB_MSG_LOCK_EN
      if (locked) eff = v & (N'(1) << lock_id);
`endif
      sel = rr_pick(eff, ptr);
      if (sel >= 0) begin
        exp_ready   = N'(1) << sel;
        e.data      = req_data[8*sel +: 8];
        e.id        = 3'(sel);
        e.start_cyc = cyc + 1;
        sbq.push_back(e);
        ptr = sel;
`ifdef UART_ARB_MSG_LOCK_EN
        locked  = !req_last[sel];
        lock_id = sel;
`endif
        if (flen > 0) begin
          busy_from  = cyc + 2;
          busy_until = cyc + 1 + flen;
          idle_from  = cyc + 3 + flen;
        end else begin
          idle_from = cyc + 7;
        end
      end
    end
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("arb_busy", 32'(arb_busy), 32'(exp_ab));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mid_reset();
    int guard = 0;
    while ((cyc < idle_from) && (guard < 50)) begin
      cycle('0, 0, 1'b0);
      guard++;
    end
    cycle(N'(1), 8, 1'b0);
    repeat (4) cycle('0, 0, 1'b0);
    req_valid = '1;
    reset     = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_tx_start", 32'(uart_tx_start), 32'(0));
    chk("rst_tx_data", 32'(uart_tx_data), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(N - 1));
    chk("rst_arb_busy", 32'(arb_busy), 32'(0));
    sbq.delete();
    ptr        = N - 1;
    locked     = 1'b0;
    busy_until = -1;
    @(negedge clk);
    @(posedge clk);
    #1;
    cyc++;
    reset     = 1'b0;
    idle_from = cyc;
  endtask

  // Monitor: every start strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (reset) last_data = 8'h00;
    if (uart_tx_start) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_start: got unexpected start at cycle %0d, required none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("tx_data", 32'(uart_tx_data), 32'(mon_e.data));
        chk("grant_id", 32'(grant_id), 32'(mon_e.id));
        chk("start_cycle", 32'(cyc), 32'(mon_e.start_cyc));
        last_data = mon_e.data;
      end
    end else begin
      chk("tx_data_hold", 32'(uart_tx_data), 32'(last_data));
      if ((sbq.size() > 0) && (sbq[0].start_cyc <= cyc)) begin
        chk("tx_start", 32'(uart_tx_start), 32'(1));
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    logic [N-1:0] v;
    int           mode;
    int           fixed;
    int           flen;
    reset        = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    uart_tx_busy = 1'b0;
    @(negedge clk);
    chk("init_req_ready", 32'(req_ready), 32'(0));
    chk("init_tx_start", 32'(uart_tx_start), 32'(0));
    chk("init_tx_data", 32'(uart_tx_data), 32'(0));
    chk("init_grant_id", 32'(grant_id), 32'(N - 1));
    chk("init_arb_busy", 32'(arb_busy), 32'(0));
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cyc       = 0;
    idle_from = 0;

    // Single requester 0, then idle until the frame completes.
    cycle(4'b0001, 3, 1'b0);
    repeat (8) cycle('0, 0, 1'b0);

    // All requesters held valid; stub UART alternates framed and silent modes.
    repeat (60) cycle('1, (($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5))), 1'b0);

    // Stray busy blocks requester 2 until it drops.
    repeat (20) cycle('0, 0, 1'b0);
    repeat (4) cycle(4'b0100, 2, 1'b1);
    repeat (6) cycle(4'b0100, 2, 1'b0);

    for (int ph = 0; ph < 10; ph++) begin
      mode  = int'($urandom_range(0, 2));
      fixed = int'($urandom_range(0, N - 1));
      for (int i = 0; i < 80; i++) begin
        case (mode)
          0:       v = '1;
          1:       v = N'(1) << fixed;
          default: v = N'($urandom);
        endcase
        flen = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
        cycle(v, flen, ($urandom_range(0, 4) == 0));
      end
    end

    mid_reset();
    repeat (40) cycle('1, 2, 1'b0);

    for (int i = 0; i < 200; i++) begin
      flen = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
      cycle(N'($urandom), flen, ($urandom_range(0, 5) == 0));
    end

    repeat (20) cycle('0, 0, 1'b0);
    chk("queue_empty", 32'(sbq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
